// File: rtl/global_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// global_stall_ctrl_pkg
// Shared definitions for the global-stall pipeline. The buffer slots, the stall
// manager and any stall monitors all decode state_o with this one enum, so the
// encodings here are part of the debug contract and must not be reordered.
//   stall_state_e : FSM state encoding (RUN=0, STALL=1, HOLD=2, FLUSH=3)
//   STALL_CNT_W   : width of the stalled-cycle statistics counter
//   cnt_w()       : register width needed to hold 0..max_val (never below 1)
// -----------------------------------------------------------------------------
package global_stall_ctrl_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } stall_state_e;

  // Width of a counter that must reach max_val. A degenerate range (for example
  // RELEASE_DELAY=0) still gets a one-bit register so no vector collapses to
  // zero width.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/global_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// global_stall_ctrl_if
// Stall/flush bundle between the buffer side of the pipeline (master) and the
// central stall manager (slave).
//   buf_full      master->slave  NUM_BUF  per-buffer "full" flag, bit i = buffer i
//   ext_stall_req master->slave  1        downstream not ready
//   flush_req     master->slave  1        pipeline flush request (pulse or level)
//   stall         slave->master  1        broadcast stall
//   flush         slave->master  1        broadcast flush
//   state_o       slave->master  2        manager FSM state (debug)
//   stall_count   slave->master  16       saturating count of stalled cycles
//   timeout_err   slave->master  1        sticky watchdog-fired flag
// -----------------------------------------------------------------------------
interface global_stall_ctrl_if #(
  parameter int NUM_BUF = 4
);
  import global_stall_ctrl_pkg::*;

  logic [NUM_BUF-1:0]     buf_full;
  logic                   ext_stall_req;
  logic                   flush_req;
  logic                   stall;
  logic                   flush;
  stall_state_e           state_o;
  logic [STALL_CNT_W-1:0] stall_count;
  logic                   timeout_err;

  modport master (
    output buf_full, ext_stall_req, flush_req,
    input  stall, flush, state_o, stall_count, timeout_err
  );

  modport slave (
    input  buf_full, ext_stall_req, flush_req,
    output stall, flush, state_o, stall_count, timeout_err
  );

endinterface

// File: rtl/global_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at a runtime ceiling instead of wrapping. Used for the
// stall watchdog, the flush-length counter and the stall statistics.
//   clk     in   1  rising-edge clock
//   reset   in   1  asynchronous, active-low
//   inc     in   1  count up by one (ignored once q == max)
//   clr     in   1  synchronous clear, wins over inc
//   max     in   W  saturation value
//   q       out  W  current count
//   at_max  out  1  q has reached max
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] q,
  output logic         at_max
);

  logic [W-1:0] r_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && !at_max) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q      = r_q;
  assign at_max = (r_q == max);

endmodule

// File: rtl/global_stall_ctrl.sv
// -----------------------------------------------------------------------------
// global_stall_ctrl
// Central stall manager. Merges the buffer-full flags and the downstream stall
// request into one broadcast stall, holds stall for RELEASE_DELAY cycles after
// every cause has gone (hysteresis), and runs a watchdog that forces a recovery
// flush if the pipeline stays stalled for STALL_TIMEOUT consecutive cycles.
//   clk    in     1  rising-edge clock
//   reset  in     1  asynchronous, active-low; outputs are valid while held
//   bus    slave     stall/flush bundle (see global_stall_ctrl_if)
// All outputs come straight from flops; a cause sampled at edge N shows as
// stall=1 right after edge N.
// Parameters:
//   NUM_BUF        buffers reporting full
//   RELEASE_DELAY  extra stalled cycles after the causes clear (0 = none)
//   STALL_TIMEOUT  consecutive STALL/HOLD cycles before the watchdog flush (>=2)
//   FLUSH_CYCLES   length of one flush event in cycles (>=1)
// -----------------------------------------------------------------------------
module global_stall_ctrl
  import global_stall_ctrl_pkg::*;
#(
  parameter int NUM_BUF       = 4,
  parameter int RELEASE_DELAY = 2,
  parameter int STALL_TIMEOUT = 64,
  parameter int FLUSH_CYCLES  = 2
) (
  input logic                clk,
  input logic                reset,
  global_stall_ctrl_if.slave bus
);

  localparam int WD_W  = cnt_w(STALL_TIMEOUT - 1);
  localparam int REL_W = cnt_w(RELEASE_DELAY);
  localparam int FC_W  = cnt_w(FLUSH_CYCLES);

  localparam logic [WD_W-1:0]        WD_MAX   = WD_W'(STALL_TIMEOUT - 1);
  localparam logic [FC_W-1:0]        FC_LAST  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [REL_W-1:0]       REL_LOAD = (RELEASE_DELAY > 0) ? REL_W'(RELEASE_DELAY - 1) : '0;
  localparam logic [STALL_CNT_W-1:0] CNT_MAX  = '1;

  if (STALL_TIMEOUT < 2) begin : g_bad_timeout
    $error("global_stall_ctrl: STALL_TIMEOUT must be at least 2");
  end
  if (FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("global_stall_ctrl: FLUSH_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  stall_state_e     r_state;
  logic             r_stall;
  logic             r_flush;
  logic             r_timeout_err;
  logic [REL_W-1:0] r_rel;

  // ---------------------------------------------------------------------------
  // Decision logic
  // ---------------------------------------------------------------------------
  logic [NUM_BUF-1:0]     w_buf_full;
  logic                   w_cause;
  stall_state_e           w_next;
  logic                   w_wd_fire;
  logic                   w_wd_inc;
  logic                   w_wd_clr;
  logic                   w_fc_inc;
  logic                   w_fc_clr;
  logic [WD_W-1:0]        w_wd_q;
  logic                   w_wd_at_max;
  logic [FC_W-1:0]        w_fc_q;
  logic                   w_fc_at_max;
  logic [STALL_CNT_W-1:0] w_stall_count;
  logic                   w_cnt_at_max;
  logic                   w_unused;

  assign w_buf_full = bus.buf_full;
  assign w_cause    = (|w_buf_full) | bus.ext_stall_req;

  // Priority in every state: flush_req > watchdog > cause > release.
  // NOTE: every always_comb output is given a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    w_wd_fire = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (bus.flush_req) begin
          w_next = ST_FLUSH;
        end else if (w_cause) begin
          w_next = ST_STALL;
        end
      end
      ST_STALL, ST_HOLD: begin
        if (bus.flush_req) begin
          w_next = ST_FLUSH;
        end else if (w_wd_at_max) begin
          w_next    = ST_FLUSH;
          w_wd_fire = 1'b1;
        end else if (w_cause) begin
          // Re-stall from HOLD keeps the watchdog running: a flapping cause
          // must not be able to hide a pipeline that never really drains.
          w_next = ST_STALL;
        end else if (r_state == ST_STALL) begin
          w_next = (RELEASE_DELAY == 0) ? ST_RUN : ST_HOLD;
        end else if (r_rel == '0) begin
          w_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // A new flush_req restarts the flush length; otherwise leave after the
        // last flush cycle, straight back into STALL if a cause is pending.
        if (!bus.flush_req && w_fc_at_max) begin
          w_next = w_cause ? ST_STALL : ST_RUN;
        end
      end
    endcase
  end

  // Watchdog runs while stalled and restarts whenever the pipeline either runs
  // again or is being flushed.
  assign w_wd_inc = (r_state == ST_STALL) || (r_state == ST_HOLD);
  assign w_wd_clr = (w_next == ST_RUN) || (w_next == ST_FLUSH);

  // Flush length restarts on entry and on every flush_req seen while flushing.
  assign w_fc_inc = (r_state == ST_FLUSH);
  assign w_fc_clr = (w_next == ST_FLUSH) && ((r_state != ST_FLUSH) || bus.flush_req);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs: stall/flush are decoded from the next state so
  // they line up with state_o on the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rel         <= '0;
    end else begin
      r_state <= w_next;
      r_stall <= (w_next != ST_RUN);
      r_flush <= (w_next == ST_FLUSH);
      if (w_wd_fire) begin
        r_timeout_err <= 1'b1;
      end
      if ((r_state == ST_STALL) && (w_next == ST_HOLD)) begin
        r_rel <= REL_LOAD;
      end else if ((r_state == ST_HOLD) && (w_next == ST_HOLD)) begin
        r_rel <= r_rel - REL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  sat_counter #(.W(WD_W)) u_wd_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_wd_inc),
    .clr    (w_wd_clr),
    .max    (WD_MAX),
    .q      (w_wd_q),
    .at_max (w_wd_at_max)
  );

  sat_counter #(.W(FC_W)) u_flush_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_fc_inc),
    .clr    (w_fc_clr),
    .max    (FC_LAST),
    .q      (w_fc_q),
    .at_max (w_fc_at_max)
  );

  // Statistics count every cycle the broadcast stall is high, flush included.
  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (r_stall),
    .clr    (1'b0),
    .max    (CNT_MAX),
    .q      (w_stall_count),
    .at_max (w_cnt_at_max)
  );

  // The FSM only needs the ceiling flags of the watchdog and flush counters and
  // the value of the statistics counter; the remaining outputs are tied off.
  assign w_unused = ^{w_wd_q, w_fc_q, w_cnt_at_max};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.stall       = r_stall;
  assign bus.flush       = r_flush;
  assign bus.state_o     = r_state;
  assign bus.stall_count = w_stall_count;
  assign bus.timeout_err = r_timeout_err;

endmodule
